// File: rtl/button_conditioner_if.sv
// Player-button bundle between the board pins / game logic and the
// button_conditioner. The conditioner takes the slave side: it receives
// the raw button levels and produces move pulses and debounced levels.
interface button_conditioner_if;
  logic leftButton;
  logic rightButton;
  logic moveLeft;
  logic moveRight;
  logic leftHeld;
  logic rightHeld;

  modport master (
    output leftButton,
    output rightButton,
    input  moveLeft,
    input  moveRight,
    input  leftHeld,
    input  rightHeld
  );

  modport slave (
    input  leftButton,
    input  rightButton,
    output moveLeft,
    output moveRight,
    output leftHeld,
    output rightHeld
  );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: turns raw, bouncy, asynchronous left/right button
// levels into clean one-cycle paddle-move pulses plus debounced levels.
// Each button: 2-flop synchroniser, debounce counter, press FSM.
// Optional feature macro: AUTOREPEAT_EN adds a REPEAT state that emits
// repeat pulses while a button stays held (default build: one pulse per press).
// While both buttons are held the pulses are suppressed and repeat timers
// are held at zero.

// One button channel.
//   state      | meaning
//   ST_IDLE    | debounced level low, waiting for an accepted press
//   ST_PRESSED | press accepted (pulse emitted unless in conflict), still held
//   ST_REPEAT  | (AUTOREPEAT_EN only) held past the first repeat, pulsing periodically
module button_conditioner_chan #(
  parameter int DEBOUNCE_CYCLES = 500000
`ifdef AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic other_held_i,
  output logic held_o,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter clears instead of reaching DEBOUNCE_CYCLES, so the toggle
  // fires while it still holds DEBOUNCE_CYCLES-1.
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW      = $clog2(RPT_MAX + 1);
  localparam logic [TW-1:0] RPT_FIRST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RPT_NEXT  = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_REPEAT} state_t;
  logic [TW-1:0] timer_q, timer_d;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_PRESSED} state_t;
`endif

  logic          sync1_q, sync2_q;
  logic          held_q, held_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  state_t        state_q, state_d;
  logic          pulse_q, pulse_d;
  logic          conflict;

  // Two-flop synchroniser; the only consumer of the raw pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing cycles, any agreement restarts.
  always_comb begin
    held_d   = held_q;
    db_cnt_d = '0;
    if (sync2_q != held_q) begin
      if (db_cnt_q == DB_LAST) begin
        held_d = ~held_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounced level and its counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      held_q   <= held_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign conflict = held_q & other_held_i;

  // Press FSM next-state and pulse decision. In REPEAT a conflict drops back
  // to PRESSED so that, once resolved, the full first-repeat delay applies.
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
`ifdef AUTOREPEAT_EN
    timer_d = timer_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (held_q) begin
          state_d = ST_PRESSED;
          pulse_d = ~conflict;
        end
      end
      ST_PRESSED: begin
        if (!held_q) begin
          state_d = ST_IDLE;
        end
`ifdef AUTOREPEAT_EN
        else if (conflict) begin
          timer_d = '0;
        end else if (timer_q == RPT_FIRST) begin
          state_d = ST_REPEAT;
          pulse_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
`ifdef AUTOREPEAT_EN
      ST_REPEAT: begin
        if (!held_q) begin
          state_d = ST_IDLE;
        end else if (conflict) begin
          state_d = ST_PRESSED;
        end else if (timer_q == RPT_NEXT) begin
          pulse_d = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef AUTOREPEAT_EN
    if (state_d != state_q) begin
      timer_d = '0;
    end
`endif
  end

  // FSM state and registered pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef AUTOREPEAT_EN
  // Repeat timer: cleared on every state change and during conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  assign held_o  = held_q;
  assign pulse_o = pulse_q;

endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave btn
);

  localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 2) && (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

  // Out-of-range parameters leave this marker scope in the elaborated hierarchy.
  if (!CFG_OK) begin : g_cfg_out_of_range
  end

  logic held_l, held_r;
  logic pulse_l, pulse_r;

  button_conditioner_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
  ) u_left (
    .clk          (clk),
    .reset        (reset),
    .raw_i        (btn.leftButton),
    .other_held_i (held_r),
    .held_o       (held_l),
    .pulse_o      (pulse_l)
  );

  button_conditioner_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
  ) u_right (
    .clk          (clk),
    .reset        (reset),
    .raw_i        (btn.rightButton),
    .other_held_i (held_l),
    .held_o       (held_r),
    .pulse_o      (pulse_r)
  );

  // A conflict that starts on the same edge a pulse was registered still
  // blanks that pulse, so neither move ever shows while both are held.
  assign btn.leftHeld  = held_l;
  assign btn.rightHeld = held_r;
  assign btn.moveLeft  = pulse_l & ~(held_l & held_r);
  assign btn.moveRight = pulse_r & ~(held_l & held_r);

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  button_conditioner_if bif();

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (bif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Level accepted once the last D synchronised samples (raw delayed by two
  // edges) all disagree with it. Pulse on accepted rise unless both held;
  // with auto-repeat, further pulses at s+RD, s+RD+RP, ... where s is the
  // later of (rise edge + 1) and the edge a conflict ended.
  int edge_cnt = 0;
  bit hist[2][$];
  bit lvl[2];
  bit lvl_p[2];
  bit conf_now;
  bit conf_p;
  int rise_e[2];
  int conf_end;
  bit exp_move[2];
  int m_pulses[2];

  task automatic model_clear();
    for (int b = 0; b < 2; b++) begin
      hist[b] = {};
      repeat (D + 2) hist[b].push_back(1'b0);
      lvl[b]      = 1'b0;
      lvl_p[b]    = 1'b0;
      rise_e[b]   = 0;
      exp_move[b] = 1'b0;
    end
    conf_now = 1'b0;
    conf_p   = 1'b0;
    conf_end = 0;
  endtask

  initial model_clear();

  always @(posedge clk) begin
    bit raw [2];
    bit q   [2];
    bit c1;
    bit all_diff;
    edge_cnt++;
    raw[0] = bif.leftButton;
    raw[1] = bif.rightButton;
    if (reset) begin
      model_clear();
    end else begin
      c1 = conf_now;
      for (int b = 0; b < 2; b++) begin
        q[b] = lvl[b] && !lvl_p[b] && !c1;
`ifdef AUTOREPEAT_EN
        if (lvl[b] && lvl_p[b] && !c1) begin
          int s;
          int d;
          s = (rise_e[b] + 1 > conf_end) ? rise_e[b] + 1 : conf_end;
          d = edge_cnt - s;
          if (d >= RD && ((d - RD) % RP) == 0) q[b] = 1'b1;
        end
`endif
        hist[b].push_back(raw[b]);
        void'(hist[b].pop_front());
        all_diff = 1'b1;
        for (int i = 0; i < D; i++)
          if (hist[b][i] == lvl[b]) all_diff = 1'b0;
        lvl_p[b] = lvl[b];
        if (all_diff) begin
          lvl[b] = !lvl[b];
          if (lvl[b]) rise_e[b] = edge_cnt;
        end
      end
      conf_p   = conf_now;
      conf_now = lvl[0] && lvl[1];
      if (conf_p && !conf_now) conf_end = edge_cnt;
      for (int b = 0; b < 2; b++) begin
        exp_move[b] = q[b] && !conf_now;
        if (exp_move[b]) m_pulses[b]++;
      end
    end
  end

  // ---------------- compare + event monitor ----------------
  int  pl_cnt = 0, pr_cnt = 0, pl_last = -1, pr_last = -1;
  int  hl_rise = -1, hr_rise_cnt = 0;
  bit  prev_hl = 1'b0, prev_hr = 1'b0;

  always @(negedge clk) begin
    chk("leftHeld",  int'(bif.leftHeld),  reset ? 0 : int'(lvl[0]));
    chk("rightHeld", int'(bif.rightHeld), reset ? 0 : int'(lvl[1]));
    chk("moveLeft",  int'(bif.moveLeft),  reset ? 0 : int'(exp_move[0]));
    chk("moveRight", int'(bif.moveRight), reset ? 0 : int'(exp_move[1]));
    chk("move_exclusive", int'(bif.moveLeft & bif.moveRight), 0);
    if (!reset) begin
      if (bif.moveLeft)  begin pl_cnt++; pl_last = edge_cnt; end
      if (bif.moveRight) begin pr_cnt++; pr_last = edge_cnt; end
      if (bif.leftHeld && !prev_hl)  hl_rise = edge_cnt;
      if (bif.rightHeld && !prev_hr) hr_rise_cnt++;
    end
    prev_hl = bif.leftHeld;
    prev_hr = bif.rightHeld;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #5;
  endtask

  task automatic clr_counts();
    pl_cnt = 0; pr_cnt = 0; pl_last = -1; pr_last = -1;
    hl_rise = -1; hr_rise_cnt = 0;
    m_pulses[0] = 0; m_pulses[1] = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int r;
    int run_l;
    int run_r;
    int exp_rep;
    bif.leftButton  = 1'b0;
    bif.rightButton = 1'b0;
    reset = 1'b1;

    // 1: reset
    cyc(5);
    chk("t1_reset_leftHeld", int'(bif.leftHeld), 0);
    chk("t1_reset_moveLeft", int'(bif.moveLeft), 0);
    reset = 1'b0;
    cyc(5);
    chk("t1_post_rightHeld", int'(bif.rightHeld), 0);
    chk("t1_post_moveRight", int'(bif.moveRight), 0);

    // 2: single clean left press
    clr_counts();
    k = edge_cnt;
    bif.leftButton = 1'b1;
    cyc(25);
    chk("t2_held_rise_edge", hl_rise - k, 10);
    chk("t2_pulse_edge", pl_last - k, 11);
    chk("t2_pulse_count", pl_cnt, 1);
    chk("t2_model_pulse_count", m_pulses[0], 1);
    chk("t2_no_moveRight", pr_cnt, 0);
    bif.leftButton = 1'b0;
    cyc(15);
    chk("t2_release_held", int'(bif.leftHeld), 0);
    chk("t2_release_no_pulse", pl_cnt, 1);

    // 3: bouncing right button, then a steady press
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      bif.rightButton = 1'b1; cyc(3);
      bif.rightButton = 1'b0; cyc(2);
    end
    cyc(15);
    chk("t3_bounce_no_held", hr_rise_cnt, 0);
    chk("t3_bounce_no_pulse", pr_cnt, 0);
    bif.rightButton = 1'b1;
    cyc(20);
    chk("t3_steady_held", hr_rise_cnt, 1);
    chk("t3_steady_pulse", pr_cnt, 1);
    bif.rightButton = 1'b0;
    cyc(15);

    // 4: conflict
    bif.leftButton = 1'b1;
    cyc(15);
    clr_counts();
    bif.rightButton = 1'b1;
    cyc(15);
    chk("t4_rightHeld", int'(bif.rightHeld), 1);
    chk("t4_conflict_no_left", pl_cnt, 0);
    chk("t4_conflict_no_right", pr_cnt, 0);
    bif.leftButton = 1'b0;
    cyc(15);
    chk("t4_left_released", int'(bif.leftHeld), 0);
    chk("t4_release_no_right", pr_cnt, 0);
    bif.rightButton = 1'b0;
    cyc(15);

    // 5: long hold (accept at k+11, debounced release at accept+57)
    clr_counts();
    k = edge_cnt;
    bif.leftButton = 1'b1;
    cyc(58);
    bif.leftButton = 1'b0;
    cyc(20);
`ifdef AUTOREPEAT_EN
    exp_rep = 9;
`else
    exp_rep = 1;
`endif
    chk("t5_hold_pulses", pl_cnt, exp_rep);
    chk("t5_model_pulses", m_pulses[0], exp_rep);

    // 6: reset mid-press
    k = edge_cnt;
    bif.leftButton = 1'b1;
    cyc(14);
    chk("t6_held_before_reset", int'(bif.leftHeld), 1);
    reset = 1'b1;
    #1;
    chk("t6_async_leftHeld", int'(bif.leftHeld), 0);
    chk("t6_async_moveLeft", int'(bif.moveLeft), 0);
    cyc(3);
    reset = 1'b0;
    clr_counts();
    r = edge_cnt;
    cyc(25);
    chk("t6_post_reset_pulses", pl_cnt, 1);
    chk("t6_post_reset_edge", pl_last - r, 11);
    bif.leftButton = 1'b0;
    cyc(15);

    // random phase: mixtures of bounces and long holds, occasional reset
    run_l = 0;
    run_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_l <= 0) begin
        bif.leftButton = 1'($urandom_range(0, 1));
        run_l = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 70);
      end
      if (run_r <= 0) begin
        bif.rightButton = 1'($urandom_range(0, 1));
        run_r = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 70);
      end
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
      end
      cyc(1);
      run_l--;
      run_r--;
    end
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
